// File: rtl/demux_1x8_regbank.sv
// Write-side steering bank: one WIDTH-bit write lands in one of eight holding registers.
// Handshaked writes, per-register written flags, and an 8-cycle sequenced clear-all.
module demux_1x8_regbank #(
    parameter int unsigned       WIDTH   = 16,
    parameter logic [WIDTH-1:0]  CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_req,
    output logic             busy,
    output logic [7:0]       written,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       written_q, written_d;
    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] regs_d [8];
    logic             wr_fire;

    assign busy     = (state_q == ST_CLEAR);
    assign wr_ready = (state_q == ST_IDLE) && !clr_req;
    assign wr_fire  = wr_valid && wr_ready;
    assign written  = written_q;

    // Each register either takes a write, takes its clear slot, or holds.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_reg
            always_comb begin
                regs_d[gi]    = regs_q[gi];
                written_d[gi] = written_q[gi];
                if (state_q == ST_CLEAR) begin
                    if (idx_q == 3'(gi)) begin
                        regs_d[gi]    = CLR_VAL;
                        written_d[gi] = 1'b0;
                    end
                end else if (wr_fire && (wr_sel == 3'(gi))) begin
                    regs_d[gi]    = wr_data;
                    written_d[gi] = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    idx_d   = 3'd0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // Index wraps naturally from 7 back to 0 on the last clear slot.
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            written_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            written_q <= written_d;
        end
    end

    assign out0 = regs_q[0];
    assign out1 = regs_q[1];
    assign out2 = regs_q[2];
    assign out3 = regs_q[3];
    assign out4 = regs_q[4];
    assign out5 = regs_q[5];
    assign out6 = regs_q[6];
    assign out7 = regs_q[7];

endmodule

// File: tb/tb_demux_1x8_regbank.sv
// Bench for demux_1x8_regbank: array/countdown model checked every cycle, plus directed literal checks.
module tb_demux_1x8_regbank;

    localparam int          W    = 16;
    localparam logic [15:0] CLRV = 16'h00FF;

    logic         clk;
    logic         rst;
    logic         wr_valid;
    logic         wr_ready;
    logic [2:0]   wr_sel;
    logic [W-1:0] wr_data;
    logic         clr_req;
    logic         busy;
    logic [7:0]   written;
    logic [W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [W-1:0] dout [8];

    demux_1x8_regbank #(.WIDTH(W), .CLR_VAL(CLRV)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_data(wr_data),
        .clr_req(clr_req), .busy(busy), .written(written),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7)
    );

    assign dout[0] = out0; assign dout[1] = out1; assign dout[2] = out2; assign dout[3] = out3;
    assign dout[4] = out4; assign dout[5] = out5; assign dout[6] = out6; assign dout[7] = out7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: plain register array plus a countdown of remaining clear slots.
    logic [W-1:0] m_regs [8];
    logic [7:0]   m_written;
    int           m_clr_left;
    int           pos;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] <= '0;
            m_written  <= 8'h00;
            m_clr_left <= 0;
        end else if (m_clr_left != 0) begin
            pos = 8 - m_clr_left;
            m_regs[pos]    <= CLRV;
            m_written[pos] <= 1'b0;
            m_clr_left     <= m_clr_left - 1;
        end else if (clr_req) begin
            m_clr_left <= 8;
        end else if (wr_valid) begin
            m_regs[wr_sel]    <= wr_data;
            m_written[wr_sel] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("model_busy", 32'(busy), 32'(m_clr_left != 0));
            check("model_ready", 32'(wr_ready), 32'((m_clr_left == 0) && !clr_req));
            check("model_written", 32'(written), 32'(m_written));
            for (int i = 0; i < 8; i++) begin
                check($sformatf("model_out%0d", i), 32'(dout[i]), 32'(m_regs[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int busy_cycles;
    int budget;

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_sel = 3'd0; wr_data = '0; clr_req = 1'b0;
        tick();
        rst = 1'b0;
        check_en = 1'b1;
        // Reset state
        for (int i = 0; i < 8; i++) check($sformatf("reset_out%0d", i), 32'(dout[i]), 32'h0);
        check("reset_written", 32'(written), 32'h00);
        check("reset_ready", 32'(wr_ready), 32'h1);
        check("reset_busy", 32'(busy), 32'h0);

        // Single write
        wr_valid = 1'b1; wr_sel = 3'd5; wr_data = 16'hBEEF;
        tick();
        wr_valid = 1'b0;
        check("wr_out5", 32'(out5), 32'hBEEF);
        check("wr_written", 32'(written), 32'h20);
        check("wr_out4", 32'(out4), 32'h0);

        // Streaming writes, one per cycle
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; wr_sel = 3'(i); wr_data = 16'h1000 + 16'(i);
            #1;
            check($sformatf("stream_ready%0d", i), 32'(wr_ready), 32'h1);
            tick();
        end
        wr_valid = 1'b0;
        check("stream_written", 32'(written), 32'hFF);
        check("stream_out0", 32'(out0), 32'h1000);
        check("stream_out5", 32'(out5), 32'h1005);
        check("stream_out7", 32'(out7), 32'h1007);

        // Same index back-to-back, last write wins
        wr_valid = 1'b1; wr_sel = 3'd3; wr_data = 16'hA5A5;
        tick();
        wr_data = 16'h5A5A;
        tick();
        wr_valid = 1'b0;
        check("b2b_out3", 32'(out3), 32'h5A5A);

        // Clear-all sequence
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cycles = 0;
        budget = 20;
        while (busy && budget > 0) begin
            check($sformatf("clr_written%0d", busy_cycles), 32'(written), 32'((8'hFF << busy_cycles) & 8'hFF));
            if (busy_cycles == 1) begin
                check("clr_out0_first", 32'(out0), 32'h00FF);
                check("clr_out1_pending", 32'(out1), 32'h1001);
            end
            busy_cycles++;
            budget--;
            tick();
        end
        check("clr_busy_cycles", 32'(busy_cycles), 32'd8);
        check("clr_ready_after", 32'(wr_ready), 32'h1);
        check("clr_written_after", 32'(written), 32'h00);
        check("clr_out7", 32'(out7), 32'h00FF);

        // clr_req and wr_valid together: clear wins; held write lands after clear
        wr_valid = 1'b1; wr_sel = 3'd2; wr_data = 16'h1234;
        tick();
        clr_req = 1'b1; wr_sel = 3'd6; wr_data = 16'h7777;
        tick();
        clr_req = 1'b0;
        check("conf_busy", 32'(busy), 32'h1);
        check("conf_not_accepted", 32'(written[6]), 32'h0);
        budget = 20;
        while (busy && budget > 0) begin
            budget--;
            tick();
        end
        check("conf_wait_bound", 32'(busy), 32'h0);
        check("conf_out6_cleared", 32'(out6), 32'h00FF);
        tick();
        wr_valid = 1'b0;
        check("conf_out6_written", 32'(out6), 32'h7777);
        check("conf_written", 32'(written), 32'h40);
        check("conf_out2_cleared", 32'(out2), 32'h00FF);

        // Reset in the middle of a clear
        wr_valid = 1'b1; wr_sel = 3'd1; wr_data = 16'hABCD;
        tick();
        wr_valid = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick(); tick();
        check("mid_busy", 32'(busy), 32'h1);
        check("mid_out1_cleared", 32'(out1), 32'h00FF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(wr_ready), 32'h1);
        check("rst_written", 32'(written), 32'h00);
        check("rst_out1", 32'(out1), 32'h0);
        check("rst_out7", 32'(out7), 32'h0);
        tick(); tick();

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
